// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared encodings for the 5-stage pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Data-memory handshake FSM states
  typedef logic [0:0] dmem_state_t;
  localparam dmem_state_t ST_IDLE = 1'b0;
  localparam dmem_state_t ST_WAIT = 1'b1;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel
// Purpose  : Forwarding select for one EX operand; MEM result beats WB result.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_ex_src,
  input  logic [4:0] i_mem_wreg,
  input  logic       i_mem_regwrite,
  input  logic [4:0] i_wb_wreg,
  input  logic       i_wb_regwrite,
  output logic [1:0] o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // $0 is hardwired zero, so a write to it never forwards
  assign w_mem_hit = i_mem_regwrite & (i_mem_wreg != 5'd0) & (i_mem_wreg == i_ex_src);
  assign w_wb_hit  = i_wb_regwrite  & (i_wb_wreg  != 5'd0) & (i_wb_wreg  == i_ex_src);

  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit) begin
      o_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule : fwd_sel
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Forwarding, load-use/redirect hazards and dmem freeze sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_wreg,
  input  logic             mem_regwrite,
  input  logic             mem_access,
  input  logic [4:0]       wb_wreg,
  input  logic             wb_regwrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             freeze,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                    c_WAIT_W    = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST = c_WAIT_W'(MAX_WAIT - 1);
  localparam logic [c_WAIT_W-1:0]   c_WAIT_ONE  = c_WAIT_W'(1);
  localparam logic [CNT_W-1:0]      c_CNT_ONE   = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Operand forwarding
  // --------------------------------------------------------------------------
  logic [4:0] w_ex_src [2];
  logic [1:0] w_fwd    [2];

  assign w_ex_src[0] = ex_rs;
  assign w_ex_src[1] = ex_rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    fwd_sel u_fwd_sel (
      .i_ex_src       (w_ex_src[gi]),
      .i_mem_wreg     (mem_wreg),
      .i_mem_regwrite (mem_regwrite),
      .i_wb_wreg      (wb_wreg),
      .i_wb_regwrite  (wb_regwrite),
      .o_sel          (w_fwd[gi])
    );
  end

  assign fwd_a = w_fwd[0];
  assign fwd_b = w_fwd[1];

  // --------------------------------------------------------------------------
  // Data-memory handshake FSM
  // --------------------------------------------------------------------------
  dmem_state_t         r_state;
  dmem_state_t         w_state_nxt;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_mem_err;
  logic                w_in_wait;
  logic                w_timeout;
  logic                w_req;
  logic                w_freeze;

  assign w_in_wait = (r_state == ST_WAIT);
  assign w_timeout = w_in_wait & ~dmem_ack & (r_wait_cnt == c_WAIT_LAST);
  // Request is gated by reset so it drops immediately, not at the next edge
  assign w_req     = rst_n & ((~w_in_wait & mem_access) | w_in_wait);
  // On timeout the pipe is released for one cycle so the access retires
  assign w_freeze  = w_req & ~dmem_ack & ~w_timeout;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (mem_access & ~dmem_ack) w_state_nxt = ST_WAIT;
      ST_WAIT: if (dmem_ack | w_timeout)   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_in_wait) begin
        r_wait_cnt <= '0;
      end else if (!w_timeout) begin
        r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
      end
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Hazard priority: freeze > redirect > load-use
  // --------------------------------------------------------------------------
  logic w_load_use;
  logic w_redirect_act;
  logic w_load_use_act;

  assign w_load_use = ex_memtoreg & ex_regwrite & (ex_wreg != 5'd0) &
                      ((id_use_rs & (id_rs == ex_wreg)) |
                       (id_use_rt & (id_rt == ex_wreg)));

  assign w_redirect_act = ~w_freeze & ex_redirect;
  assign w_load_use_act = ~w_freeze & ~ex_redirect & w_load_use;

  assign dmem_req   = w_req;
  assign freeze     = w_freeze;
  assign stall_pc   = w_freeze | w_load_use_act;
  assign stall_ifid = w_freeze | w_load_use_act;
  assign flush_ifid = w_redirect_act;
  assign flush_idex = w_redirect_act | w_load_use_act;
  assign mem_err    = r_mem_err;

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((w_freeze | w_load_use_act) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
      if (w_redirect_act && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int c_CNT_W = 16;

  logic              clk;
  logic              rst_n;
  logic [4:0]        id_rs, id_rt;
  logic              id_use_rs, id_use_rt;
  logic [4:0]        ex_rs, ex_rt, ex_wreg;
  logic              ex_regwrite, ex_memtoreg, ex_redirect;
  logic [4:0]        mem_wreg;
  logic              mem_regwrite, mem_access;
  logic [4:0]        wb_wreg;
  logic              wb_regwrite;
  logic              dmem_ack;
  logic              dmem_req;
  logic [1:0]        fwd_a, fwd_b;
  logic              stall_pc, stall_ifid, freeze, flush_ifid, flush_idex, mem_err;
  logic [c_CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp;
  int n_err;

  pipe_hazard_ctrl #(
    .MAX_WAIT (4),
    .CNT_W    (c_CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_wreg      (ex_wreg),
    .ex_regwrite  (ex_regwrite),
    .ex_memtoreg  (ex_memtoreg),
    .ex_redirect  (ex_redirect),
    .mem_wreg     (mem_wreg),
    .mem_regwrite (mem_regwrite),
    .mem_access   (mem_access),
    .wb_wreg      (wb_wreg),
    .wb_regwrite  (wb_regwrite),
    .dmem_ack     (dmem_ack),
    .dmem_req     (dmem_req),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_pc     (stall_pc),
    .stall_ifid   (stall_ifid),
    .freeze       (freeze),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_wreg = 5'd0;
    ex_regwrite = 1'b0; ex_memtoreg = 1'b0; ex_redirect = 1'b0;
    mem_wreg = 5'd0; mem_regwrite = 1'b0; mem_access = 1'b0;
    wb_wreg = 5'd0; wb_regwrite = 1'b0; dmem_ack = 1'b0;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  // Status nibble {freeze, stall_pc, stall_ifid, dmem_req}
  function automatic logic [31:0] stat();
    return {28'd0, freeze, stall_pc, stall_ifid, dmem_req};
  endfunction

  function automatic logic [31:0] flushes();
    return {30'd0, flush_ifid, flush_idex};
  endfunction

  task automatic set_load_use();
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd1;
    id_rs = 5'd1; id_use_rs = 1'b1; id_rt = 5'd3; id_use_rt = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clear_inputs();
    mem_access = 1'b1;
    #2;
    // Reset state, with a pending access that must not raise the request
    check("rst_req",   32'(dmem_req),  32'd0);
    check("rst_err",   32'(mem_err),   32'd0);
    check("rst_scnt",  32'(stall_cnt), 32'd0);
    check("rst_fcnt",  32'(flush_cnt), 32'd0);
    check("rst_fwd",   32'({fwd_a, fwd_b}), 32'd0);

    // lw $1 in EX, add $2,$1,$3 in ID
    do_reset();
    set_load_use();
    #1;
    check("lu_stall",  32'({stall_pc, stall_ifid, flush_idex, flush_ifid}), 32'b1110);
    check("lu_frz",    32'(freeze), 32'd0);
    tick();
    clear_inputs();
    mem_wreg = 5'd1; mem_regwrite = 1'b1; mem_access = 1'b1; dmem_ack = 1'b1;
    id_rs = 5'd1; id_use_rs = 1'b1; id_rt = 5'd3; id_use_rt = 1'b1;
    #1;
    check("lu_bub_st", stat(), 32'b0001);
    check("lu_bub_fl", flushes(), 32'd0);
    check("lu_scnt1",  32'(stall_cnt), 32'd1);
    tick();
    clear_inputs();
    ex_rs = 5'd1; ex_rt = 5'd3; wb_wreg = 5'd1; wb_regwrite = 1'b1;
    #1;
    check("lu_fwd_a",  32'(fwd_a), 32'b01);
    check("lu_fwd_b",  32'(fwd_b), 32'b00);
    check("lu_scnt",   32'(stall_cnt), 32'd1);

    // add $1 then sub $4,$1,$1; older $1 also in WB so MEM must win
    do_reset();
    ex_rs = 5'd1; ex_rt = 5'd1;
    mem_wreg = 5'd1; mem_regwrite = 1'b1;
    wb_wreg = 5'd1; wb_regwrite = 1'b1;
    #1;
    check("fw_mem",    32'({fwd_a, fwd_b}), 32'b1010);
    check("fw_nostl",  stat(), 32'd0);
    mem_wreg = 5'd0; wb_wreg = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
    #1;
    check("fw_r0",     32'({fwd_a, fwd_b}), 32'd0);
    mem_regwrite = 1'b0; mem_wreg = 5'd5; wb_wreg = 5'd5; ex_rt = 5'd5; ex_rs = 5'd6;
    #1;
    check("fw_wb_b",   32'({fwd_a, fwd_b}), 32'b0001);

    // Access acked on the 4th cycle
    do_reset();
    mem_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mw_wait%0d", i), stat(), 32'b1111);
      tick();
    end
    dmem_ack = 1'b1;
    #1;
    check("mw_ack",    stat(), 32'b0001);
    tick();
    clear_inputs();
    #1;
    check("mw_idle",   stat(), 32'd0);
    check("mw_scnt",   32'(stall_cnt), 32'd3);

    // Redirect held while frozen; load-use also present at thaw
    do_reset();
    mem_access = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("rf_frz%0d", i), flushes(), 32'd0);
      tick();
    end
    dmem_ack = 1'b1;
    set_load_use();
    #1;
    check("rf_thaw",   flushes(), 32'b11);
    check("rf_nostl",  32'({stall_pc, stall_ifid, freeze}), 32'd0);
    tick();
    clear_inputs();
    #1;
    check("rf_after",  flushes(), 32'd0);
    check("rf_fcnt",   32'(flush_cnt), 32'd1);
    check("rf_scnt",   32'(stall_cnt), 32'd2);

    // Timeout with MAX_WAIT=4
    do_reset();
    mem_access = 1'b1;
    #1;
    check("to_c0",     stat(), 32'b1111);
    tick();
    for (int i = 1; i < 4; i++) begin
      #1;
      check($sformatf("to_c%0d", i), stat(), 32'b1111);
      check($sformatf("to_err%0d", i), 32'(mem_err), 32'd0);
      tick();
    end
    #1;
    check("to_rel",    stat(), 32'b0001);
    tick();
    mem_access = 1'b0;
    #1;
    check("to_err",    32'(mem_err), 32'd1);
    check("to_idle",   stat(), 32'd0);
    check("to_scnt",   32'(stall_cnt), 32'd4);
    // Reset while waiting again
    mem_access = 1'b1;
    tick();
    #1;
    check("rw_inwait", stat(), 32'b1111);
    rst_n = 1'b0;
    #1;
    check("rw_req",    32'(dmem_req), 32'd0);
    check("rw_err",    32'(mem_err), 32'd0);
    check("rw_scnt",   32'(stall_cnt), 32'd0);
    mem_access = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    #1;
    check("rw_idle",   stat(), 32'd0);

    // Saturation
    do_reset();
    set_load_use();
    repeat (70000) @(posedge clk);
    #1;
    check("sat_scnt",  32'(stall_cnt), 32'h0000FFFF);
    check("sat_fcnt",  32'(flush_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
